// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit demo CPU: opcodes, instruction fields, 7-segment codes.
package cpu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned INSN_W = 16;

    // Instruction field positions: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 10;
    localparam int unsigned RS_MSB  = 9;
    localparam int unsigned RS_LSB  = 8;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LI   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_OUTL = 4'h8;
    localparam logic [3:0] OP_OUTR = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } cpu_state_e;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Segment order {a,b,c,d,e,f,g,dp}, active-high
    function automatic logic [7:0] seg_of(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hFC;
            4'h1: s = 8'h60;
            4'h2: s = 8'hDA;
            4'h3: s = 8'hF2;
            4'h4: s = 8'h66;
            4'h5: s = 8'hB6;
            4'h6: s = 8'hBE;
            4'h7: s = 8'hE0;
            4'h8: s = 8'hFE;
            4'h9: s = 8'hF6;
            4'hA: s = 8'hEE;
            4'hB: s = 8'h3E;
            4'hC: s = 8'h9C;
            4'hD: s = 8'h7A;
            4'hE: s = 8'h9E;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cpu_core_top_seg_display.sv
// Eight-digit multiplexed 7-segment driver; digits 0,1 show the PC when PC_DISPLAY_EN is defined.
module seg_display
    import cpu_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic       clk_100,
    input  logic       rst_n,
    input  logic [7:0] out_l,
    input  logic [7:0] out_r,
    input  logic [7:0] pc,
    output logic [7:0] tube_scan,
    output logic [7:0] tube_signal_left,
    output logic [7:0] tube_signal_right
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       digit_idx;
    logic [7:0]       pattern;

    // Dwell SCAN_DIV clocks per digit, then advance the one-hot select
    always_ff @(posedge clk_100) begin
        if (rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            tube_scan <= 8'h80;
        end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 3'd1;
            tube_scan <= 8'h80 >> (digit_idx + 3'd1);
        end else begin
            scan_cnt  <= scan_cnt + CNT_W'(1);
        end
    end

`ifndef PC_DISPLAY_EN
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

    always_comb begin
        pattern = SEG_BLANK;
        case (digit_idx)
`ifdef PC_DISPLAY_EN
            3'd0: pattern = seg_of(pc[7:4]);
            3'd1: pattern = seg_of(pc[3:0]);
`endif
            3'd2: pattern = seg_of(out_l[7:4]);
            3'd3: pattern = seg_of(out_l[3:0]);
            3'd6: pattern = seg_of(out_r[7:4]);
            3'd7: pattern = seg_of(out_r[3:0]);
            default: pattern = SEG_BLANK;
        endcase
    end

    // Only the bank owning the active digit is driven
    assign tube_signal_left  = digit_idx[2] ? SEG_BLANK : pattern;
    assign tube_signal_right = digit_idx[2] ? pattern : SEG_BLANK;

endmodule

// File: rtl/cpu_core_top.sv
// Single-cycle 8-bit CPU with built-in ROM, 4x8 register file and 7-segment output.
// Optional macro PC_DISPLAY_EN shows the PC on the two leftmost digits.
module cpu_core_top
    import cpu_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned ROM_DEPTH = 16
) (
    input  logic       clk_100,
    input  logic       rst_n,
    input  logic       finish,
    input  logic [7:0] switch_in,
    output logic [7:0] switch,
    output logic [7:0] test_pc,
    output logic [7:0] tube_scan,
    output logic [7:0] tube_signal_left,
    output logic [7:0] tube_signal_right
);

    cpu_state_e          state, state_n;
    logic [7:0]          pc, pc_n;
    logic [DATA_W-1:0]   regs   [4];
    logic [DATA_W-1:0]   regs_n [4];
    logic [7:0]          out_l, out_l_n;
    logic [7:0]          out_r, out_r_n;

    logic [INSN_W-1:0]   insn;
    logic [3:0]          op;
    logic [1:0]          rd, rs;
    logic [7:0]          imm;
    logic [7:0]          rd_val, rs_val;

    // Program: out_r = sum(1..switch) mod 256
    function automatic logic [INSN_W-1:0] rom_word(input logic [7:0] addr);
        logic [INSN_W-1:0] w;
        w = 16'h0000;
        if (32'(addr) < ROM_DEPTH) begin
            case (addr)
                8'd0: w = 16'h7400;
                8'd1: w = 16'h1000;
                8'd2: w = 16'h1800;
                8'd3: w = 16'h8400;
                8'd4: w = 16'hA608;
                8'd5: w = 16'h2100;
                8'd6: w = 16'h64FF;
                8'd7: w = 16'hC004;
                8'd8: w = 16'h9000;
                8'd9: w = 16'hF000;
                default: w = 16'h0000;
            endcase
        end
        return w;
    endfunction

    assign insn   = rom_word(pc);
    assign op     = insn[OP_MSB:OP_LSB];
    assign rd     = insn[RD_MSB:RD_LSB];
    assign rs     = insn[RS_MSB:RS_LSB];
    assign imm    = insn[IMM_MSB:IMM_LSB];
    assign rd_val = regs[rd];
    assign rs_val = regs[rs];

    always_ff @(posedge clk_100) begin
        if (rst_n) begin
            state  <= ST_RUN;
            pc     <= '0;
            out_l  <= '0;
            out_r  <= '0;
            switch <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            out_l  <= out_l_n;
            out_r  <= out_r_n;
            switch <= switch_in;
            regs   <= regs_n;
        end
    end

    // Execute: freeze or halt holds all architectural state
    always_comb begin
        state_n = state;
        pc_n    = pc + 8'd1;
        out_l_n = out_l;
        out_r_n = out_r;
        regs_n  = regs;
        if (finish || state == ST_HALT) begin
            pc_n = pc;
        end else begin
            case (op)
                OP_LI:   regs_n[rd] = imm;
                OP_ADD:  regs_n[rd] = rd_val + rs_val;
                OP_SUB:  regs_n[rd] = rd_val - rs_val;
                OP_AND:  regs_n[rd] = rd_val & rs_val;
                OP_OR:   regs_n[rd] = rd_val | rs_val;
                OP_ADDI: regs_n[rd] = rd_val + imm;
                // Takes the value being latched into switch on this same edge
                OP_IN:   regs_n[rd] = switch_in;
                OP_OUTL: out_l_n = rd_val;
                OP_OUTR: out_r_n = rd_val;
                OP_BEQ:  if (rd_val == rs_val) pc_n = imm;
                OP_BNE:  if (rd_val != rs_val) pc_n = imm;
                OP_JMP:  pc_n = imm;
                OP_HALT: begin
                    state_n = ST_HALT;
                    pc_n    = pc;
                end
                default: ;
            endcase
        end
    end

    assign test_pc = pc;

    seg_display #(
        .SCAN_DIV(SCAN_DIV)
    ) u_seg_display (
        .clk_100          (clk_100),
        .rst_n            (rst_n),
        .out_l            (out_l),
        .out_r            (out_r),
        .pc               (pc),
        .tube_scan        (tube_scan),
        .tube_signal_left (tube_signal_left),
        .tube_signal_right(tube_signal_right)
    );

endmodule

// File: tb/tb_cpu_core_top.sv
// Self-checking bench for cpu_core_top: program results observed through the scanned display.
module tb_cpu_core_top;

    logic       clk_100 = 1'b0;
    logic       rst_n;
    logic       finish;
    logic [7:0] switch_in;
    logic [7:0] switch;
    logic [7:0] test_pc;
    logic [7:0] tube_scan;
    logic [7:0] tube_signal_left;
    logic [7:0] tube_signal_right;

    always #5 clk_100 = ~clk_100;

    cpu_core_top #(
        .SCAN_DIV (4),
        .ROM_DEPTH(16)
    ) dut (
        .clk_100          (clk_100),
        .rst_n            (rst_n),
        .finish           (finish),
        .switch_in        (switch_in),
        .switch           (switch),
        .test_pc          (test_pc),
        .tube_scan        (tube_scan),
        .tube_signal_left (tube_signal_left),
        .tube_signal_right(tube_signal_right)
    );

    localparam logic [7:0] HEX [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                         8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    typedef struct packed {
        logic [7:0] sw;
        logic [7:0] out_l;
        logic [7:0] out_r;
    } vec_t;

    vec_t vecs [5];
    vec_t sb [$];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic wait_pc(input logic [7:0] target, input int budget);
        int k;
        k = 0;
        while (test_pc !== target && k < budget) begin
            @(negedge clk_100);
            k++;
        end
        check($sformatf("reach pc %02h", target), test_pc, target);
    endtask

    task automatic get_digit(input int idx, output logic [7:0] l, output logic [7:0] r);
        logic [7:0] sel;
        int k;
        sel = 8'h80;
        sel = sel >> idx;
        k = 0;
        while (tube_scan !== sel && k < 40) begin
            @(negedge clk_100);
            k++;
        end
        check($sformatf("scan digit %0d", idx), tube_scan, sel);
        l = tube_signal_left;
        r = tube_signal_right;
    endtask

    task automatic check_display(input vec_t e);
        logic [7:0] l, r;
        logic [7:0] d0, d1;
`ifdef PC_DISPLAY_EN
        d0 = HEX[0];
        d1 = HEX[9];
`else
        d0 = 8'h00;
        d1 = 8'h00;
`endif
        get_digit(0, l, r); check("d0 left", l, d0); check("d0 right", r, 8'h00);
        get_digit(1, l, r); check("d1 left", l, d1);
        get_digit(2, l, r); check("d2 left", l, HEX[e.out_l[7:4]]); check("d2 right", r, 8'h00);
        get_digit(3, l, r); check("d3 left", l, HEX[e.out_l[3:0]]);
        get_digit(4, l, r); check("d4 right", r, 8'h00); check("d4 left", l, 8'h00);
        get_digit(6, l, r); check("d6 right", r, HEX[e.out_r[7:4]]); check("d6 left", l, 8'h00);
        get_digit(7, l, r); check("d7 right", r, HEX[e.out_r[3:0]]);
    endtask

    task automatic restart(input logic [7:0] sw);
        switch_in = sw;
        rst_n = 1'b1;
        repeat (2) @(negedge clk_100);
        rst_n = 1'b0;
    endtask

    // Program has halted; pop the expectation pushed at launch and compare
    task automatic finish_run();
        vec_t e;
        wait_pc(8'h09, 3000);
        repeat (3) @(negedge clk_100);
        check("halt holds pc", test_pc, 8'h09);
        if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL scoreboard empty: got 0 entries, expected 1");
        end else begin
            e = sb.pop_front();
            check("switch echo", switch, e.sw);
            check_display(e);
        end
    endtask

    initial begin
        logic [7:0] prev;
        int changes;

        vecs[0] = '{sw: 8'h07, out_l: 8'h07, out_r: 8'h1C};
        vecs[1] = '{sw: 8'h00, out_l: 8'h00, out_r: 8'h00};
        vecs[2] = '{sw: 8'h03, out_l: 8'h03, out_r: 8'h06};
        vecs[3] = '{sw: 8'h0A, out_l: 8'h0A, out_r: 8'h37};
        vecs[4] = '{sw: 8'hFF, out_l: 8'hFF, out_r: 8'h80};

        // Reset state
        rst_n = 1'b1;
        finish = 1'b0;
        switch_in = 8'h07;
        repeat (3) @(negedge clk_100);
        check("rst pc", test_pc, 8'h00);
        check("rst scan", tube_scan, 8'h80);
        check("rst left", tube_signal_left, 8'h00);
        check("rst right", tube_signal_right, 8'h00);
        check("rst switch", switch, 8'h00);
        rst_n = 1'b0;
        @(negedge clk_100);
        check("switch after release", switch, 8'h07);
        check("pc after release", test_pc, 8'h01);

        // Table of switch settings
        for (int i = 0; i < 5; i++) begin
            restart(vecs[i].sw);
            sb.push_back(vecs[i]);
            finish_run();
        end

        // Freeze mid-loop for 20 cycles
        restart(8'h07);
        sb.push_back(vecs[0]);
        wait_pc(8'h05, 200);
        finish = 1'b1;
        prev = tube_scan;
        changes = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_100);
            if (tube_scan !== prev) changes++;
            prev = tube_scan;
        end
        check("freeze pc", test_pc, 8'h05);
        check("scan during freeze", 8'(changes >= 4), 8'h01);
        finish = 1'b0;
        finish_run();

        // Reset asserted at PC=5 mid-program
        restart(8'hFF);
        wait_pc(8'h05, 200);
        rst_n = 1'b1;
        @(negedge clk_100);
        check("mid rst pc", test_pc, 8'h00);
        check("mid rst scan", tube_scan, 8'h80);
        check("mid rst left", tube_signal_left, 8'h00);
        check("mid rst right", tube_signal_right, 8'h00);
        check("mid rst switch", switch, 8'h00);
        rst_n = 1'b0;
        @(negedge clk_100);
        check("mid rst restart pc", test_pc, 8'h01);
        sb.push_back(vecs[4]);
        finish_run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
